// File: rtl/rgf_pwm_pkg.sv
// rtl/rgf_pwm_pkg.sv - address map, bit positions, default widths and register typedefs for rgf_pwm_nch
package rgf_pwm_pkg;

  localparam logic [7:0] ADDR_PWM_CFG = 8'h00;
  localparam logic [7:0] ADDR_CTRL    = 8'h04;
  localparam logic [7:0] ADDR_STATUS  = 8'h08;
  localparam logic [7:0] ADDR_CH_BASE = 8'h10;

  localparam int CTRL_COMMIT_BIT   = 0;
  localparam int CTRL_AUTO_BIT     = 1;
  localparam int CTRL_LOCK_BIT     = 2;
  localparam int STAT_PENDING_BIT  = 0;
  localparam int STAT_WR_ERR_BIT   = 1;
  localparam int STAT_CNT_LSB      = 8;

  localparam int DEF_FREQ_W   = 13;
  localparam int DEF_MAG_W    = 2;
  localparam int DEF_PHASE_W  = 9;
  localparam int DEF_FREQ_RST = 10;

  typedef struct packed {
    logic [15:0] sweep_time;
    logic [15:0] time_slots;
  } pwm_cfg_t;

  typedef struct packed {
    logic [DEF_PHASE_W-1:0] init_phase;
    logic [DEF_MAG_W-1:0]   magnitude;
    logic [DEF_FREQ_W-1:0]  freq;
  } ch_lut_t;

  typedef struct packed {
    logic [28:0] rsvd;
    logic        lock;
    logic        auto_commit;
    logic        commit;
  } ctrl_t;

  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  commit_cnt;
    logic [5:0]  rsvd_lo;
    logic        wr_err;
    logic        pending;
  } status_t;

endpackage

// File: rtl/rgf_pwm_nch_if.sv
// rtl/rgf_pwm_nch_if.sv - register bus between address decoder and rgf_pwm_nch
interface rgf_pwm_nch_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_en;
  logic                  rd_en;
  logic                  addr_decoder_leg;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output addr, wr_en, rd_en, addr_decoder_leg, wdata, input rdata);
  modport slave  (input addr, wr_en, rd_en, addr_decoder_leg, wdata, output rdata);
endinterface

// File: rtl/rgf_pwm_ch_reg.sv
// rtl/rgf_pwm_ch_reg.sv - one channel's shadow/active LUT register pair
module rgf_pwm_ch_reg
  import rgf_pwm_pkg::*;
#(
  parameter int FREQ_W   = DEF_FREQ_W,
  parameter int MAG_W    = DEF_MAG_W,
  parameter int PHASE_W  = DEF_PHASE_W,
  parameter int FREQ_RST = DEF_FREQ_RST
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             we_i,
  input  logic                             commit_i,
  input  logic [FREQ_W+MAG_W+PHASE_W-1:0]  wdata_i,
  output logic [FREQ_W+MAG_W+PHASE_W-1:0]  shadow_o,
  output logic [FREQ_W-1:0]                act_freq_o,
  output logic [MAG_W-1:0]                 act_mag_o,
  output logic [PHASE_W-1:0]               act_phase_o
);
  localparam int LUT_W = FREQ_W + MAG_W + PHASE_W;
  localparam logic [LUT_W-1:0] RST_VAL = LUT_W'(FREQ_W'(FREQ_RST));

  logic [LUT_W-1:0] shadow_q, shadow_d;
  logic [LUT_W-1:0] active_q, active_d;

  // Shadow takes bus writes; active snapshots the pre-edge shadow on commit.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (we_i)     shadow_d = wdata_i;
    if (commit_i) active_d = shadow_q;
  end

  // Register pair with synchronous reset to the default LUT entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= RST_VAL;
      active_q <= RST_VAL;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign shadow_o    = shadow_q;
  assign act_freq_o  = active_q[FREQ_W-1:0];
  assign act_mag_o   = active_q[FREQ_W +: MAG_W];
  assign act_phase_o = active_q[FREQ_W+MAG_W +: PHASE_W];

endmodule

// File: rtl/rgf_pwm_nch.sv
// rtl/rgf_pwm_nch.sv - double-buffered N-channel PWM register file; RGF_PWM_NCH_COMMIT_CNT_EN adds the commit counter
module rgf_pwm_nch
  import rgf_pwm_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int FREQ_W     = DEF_FREQ_W,
  parameter int MAG_W      = DEF_MAG_W,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int FREQ_RST   = DEF_FREQ_RST
) (
  input  logic                      clk,
  input  logic                      rst_n,
  rgf_pwm_nch_if.slave              bus,
  input  logic                      sweep_tick,
  output logic [15:0]               hw_pwm_time_slots,
  output logic [15:0]               hw_pwm_sweep_time,
  output logic [NUM_CH*FREQ_W-1:0]  hw_output_freq,
  output logic [NUM_CH*MAG_W-1:0]   hw_magnitude,
  output logic [NUM_CH*PHASE_W-1:0] hw_init_phase,
  output logic                      hw_cfg_update
);
  localparam int LUT_W = FREQ_W + MAG_W + PHASE_W;
  localparam int IW    = ADDR_WIDTH - 2;

  logic          wr_acc, rd_acc, aligned;
  logic          hit_cfg, hit_ctrl, hit_stat, hit_ch, hit_any;
  logic          shadow_ok, err_set, manual, commit;
  logic [IW-1:0] ch_idx;
  logic [7:0]    cnt_rd;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic [LUT_W-1:0]      ch_shadow [NUM_CH];

  pwm_cfg_t cfg_sh_q, cfg_sh_d, cfg_act_q, cfg_act_d;
  logic     auto_q, auto_d, lock_q, lock_d, pending_q, pending_d;
  logic     wr_err_q, wr_err_d, upd_q;

  assign wr_acc   = bus.wr_en & bus.addr_decoder_leg;
  assign rd_acc   = bus.rd_en & bus.addr_decoder_leg;
  assign aligned  = (bus.addr[1:0] == 2'b00);
  assign hit_cfg  = (bus.addr == ADDR_WIDTH'(ADDR_PWM_CFG));
  assign hit_ctrl = (bus.addr == ADDR_WIDTH'(ADDR_CTRL));
  assign hit_stat = (bus.addr == ADDR_WIDTH'(ADDR_STATUS));
  // Index is only meaningful once addr >= channel base, so no wrap concerns.
  assign ch_idx   = bus.addr[ADDR_WIDTH-1:2] - IW'(ADDR_CH_BASE >> 2);
  assign hit_ch   = aligned && (bus.addr >= ADDR_WIDTH'(ADDR_CH_BASE)) && (ch_idx < IW'(NUM_CH));
  assign hit_any  = hit_cfg | hit_ctrl | hit_stat | hit_ch;

  assign shadow_ok = wr_acc & (hit_cfg | hit_ch) & ~lock_q;
  assign err_set   = wr_acc & (~hit_any | ((hit_cfg | hit_ch) & lock_q));
  assign manual    = wr_acc & hit_ctrl & bus.wdata[CTRL_COMMIT_BIT];
  // An accepted shadow write defers auto commit so a half-updated set never goes live.
  assign commit    = manual | (auto_q & pending_q & sweep_tick & ~shadow_ok);

  // Next state of CTRL/STATUS bits and the PWM_CFG shadow/active pair.
  always_comb begin
    auto_d    = auto_q;
    lock_d    = lock_q;
    pending_d = pending_q;
    wr_err_d  = wr_err_q;
    cfg_sh_d  = cfg_sh_q;
    cfg_act_d = cfg_act_q;
    if (wr_acc & hit_ctrl) begin
      auto_d = bus.wdata[CTRL_AUTO_BIT];
      lock_d = lock_q | bus.wdata[CTRL_LOCK_BIT];
    end
    if (wr_acc & hit_stat & bus.wdata[STAT_WR_ERR_BIT]) wr_err_d = 1'b0;
    if (err_set) wr_err_d = 1'b1;
    if (shadow_ok & hit_cfg) cfg_sh_d = pwm_cfg_t'(bus.wdata[31:0]);
    if (shadow_ok) pending_d = 1'b1;
    if (commit) begin
      pending_d = 1'b0;
      cfg_act_d = cfg_sh_q;
    end
  end

  // Control/status state registers; hw_cfg_update follows a commit edge by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      auto_q    <= 1'b0;
      lock_q    <= 1'b0;
      pending_q <= 1'b0;
      wr_err_q  <= 1'b0;
      cfg_sh_q  <= '0;
      cfg_act_q <= '0;
      upd_q     <= 1'b0;
    end else begin
      auto_q    <= auto_d;
      lock_q    <= lock_d;
      pending_q <= pending_d;
      wr_err_q  <= wr_err_d;
      cfg_sh_q  <= cfg_sh_d;
      cfg_act_q <= cfg_act_d;
      upd_q     <= commit;
    end
  end

`ifdef RGF_PWM_NCH_COMMIT_CNT_EN
  logic [7:0] cnt_q, cnt_d;
  assign cnt_d = commit ? cnt_q + 8'd1 : cnt_q;
  // Free-wrapping commit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end
  assign cnt_rd = cnt_q;
`else
  assign cnt_rd = 8'd0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rgf_pwm_ch_reg #(
      .FREQ_W   (FREQ_W),
      .MAG_W    (MAG_W),
      .PHASE_W  (PHASE_W),
      .FREQ_RST (FREQ_RST)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .we_i        (shadow_ok & hit_ch & (ch_idx == IW'(c))),
      .commit_i    (commit),
      .wdata_i     (bus.wdata[LUT_W-1:0]),
      .shadow_o    (ch_shadow[c]),
      .act_freq_o  (hw_output_freq[c*FREQ_W +: FREQ_W]),
      .act_mag_o   (hw_magnitude[c*MAG_W +: MAG_W]),
      .act_phase_o (hw_init_phase[c*PHASE_W +: PHASE_W])
    );
  end

  // Combinational read mux; shadow values are what software sees.
  always_comb begin
    rdata_c = '0;
    if (rd_acc) begin
      if (hit_cfg) rdata_c = DATA_WIDTH'(cfg_sh_q);
      if (hit_ctrl) begin
        rdata_c[CTRL_AUTO_BIT] = auto_q;
        rdata_c[CTRL_LOCK_BIT] = lock_q;
      end
      if (hit_stat) begin
        rdata_c[STAT_PENDING_BIT]    = pending_q;
        rdata_c[STAT_WR_ERR_BIT]     = wr_err_q;
        rdata_c[STAT_CNT_LSB +: 8]   = cnt_rd;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (hit_ch && (ch_idx == IW'(c))) rdata_c = DATA_WIDTH'(ch_shadow[c]);
      end
    end
  end

  assign bus.rdata         = rdata_c;
  assign hw_pwm_time_slots = cfg_act_q.time_slots;
  assign hw_pwm_sweep_time = cfg_act_q.sweep_time;
  assign hw_cfg_update     = upd_q;

endmodule

// File: tb/tb_rgf_pwm_nch.sv
// tb/tb_rgf_pwm_nch.sv - directed scoreboard bench for rgf_pwm_nch
module tb_rgf_pwm_nch;
  localparam int NUM_CH = 3;
`ifdef RGF_PWM_NCH_COMMIT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic sweep_tick;
  logic [15:0] hw_pwm_time_slots, hw_pwm_sweep_time;
  logic [NUM_CH*13-1:0] hw_output_freq;
  logic [NUM_CH*2-1:0]  hw_magnitude;
  logic [NUM_CH*9-1:0]  hw_init_phase;
  logic hw_cfg_update;

  rgf_pwm_nch_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

  rgf_pwm_nch #(.NUM_CH(NUM_CH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .sweep_tick        (sweep_tick),
    .hw_pwm_time_slots (hw_pwm_time_slots),
    .hw_pwm_sweep_time (hw_pwm_sweep_time),
    .hw_output_freq    (hw_output_freq),
    .hw_magnitude      (hw_magnitude),
    .hw_init_phase     (hw_init_phase),
    .hw_cfg_update     (hw_cfg_update)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] cnt_field(input int n);
    return CNT_EN ? 32'((n % 256) << 8) : 32'd0;
  endfunction

  function automatic logic [31:0] fq(input int c);
    return 32'(hw_output_freq[c*13 +: 13]);
  endfunction

  function automatic logic [31:0] mg(input int c);
    return 32'(hw_magnitude[c*2 +: 2]);
  endfunction

  function automatic logic [31:0] ph(input int c);
    return 32'(hw_init_phase[c*9 +: 9]);
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed %h with no expected value", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic obs_chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    push(tag, exp);
    pop_chk(obs);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic tick);
    @(negedge clk);
    bus.addr   = a[5:0];
    bus.wdata  = d;
    bus.wr_en  = 1'b1;
    sweep_tick = tick;
    @(posedge clk);
    #1;
    bus.wr_en  = 1'b0;
    sweep_tick = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [31:0] exp, input logic leg);
    @(negedge clk);
    bus.addr             = a[5:0];
    bus.rd_en            = 1'b1;
    bus.addr_decoder_leg = leg;
    push(tag, exp);
    #1;
    pop_chk(bus.rdata);
    bus.rd_en            = 1'b0;
    bus.addr_decoder_leg = 1'b1;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    sweep_tick = 1'b1;
    @(posedge clk);
    #1;
    sweep_tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    sweep_tick = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr_decoder_leg = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state
    read_chk("rst_ch2", 8'h18, 32'h0000000A, 1'b1);
    read_chk("rst_status", 8'h08, 32'h0, 1'b1);
    read_chk("rst_cfg", 8'h00, 32'h0, 1'b1);
    obs_chk("rst_freq2", fq(2), 32'd10);
    obs_chk("rst_upd", 32'(hw_cfg_update), 32'd0);

    // shadow write then manual commit
    bus_write(8'h14, 32'h00812345, 1'b0);
    read_chk("sh_ch1", 8'h14, 32'h00812345, 1'b1);
    read_chk("pend_set", 8'h08, 32'h1, 1'b1);
    obs_chk("act_unchanged", fq(1), 32'd10);
    push("cm_freq1", 32'h345);
    push("cm_mag1", 32'h1);
    push("cm_phase1", 32'h102);
    push("cm_upd", 32'h1);
    bus_write(8'h04, 32'h1, 1'b0);
    pop_chk(fq(1));
    pop_chk(mg(1));
    pop_chk(ph(1));
    pop_chk(32'(hw_cfg_update));
    @(posedge clk);
    #1;
    obs_chk("upd_one_cycle", 32'(hw_cfg_update), 32'd0);
    read_chk("status_cnt1", 8'h08, cnt_field(1), 1'b1);

    // auto commit deferred by coinciding shadow write
    bus_write(8'h04, 32'h2, 1'b0);
    push("defer_upd", 32'h0);
    push("defer_slots", 32'h0);
    bus_write(8'h00, 32'h00200010, 1'b1);
    pop_chk(32'(hw_cfg_update));
    pop_chk(32'(hw_pwm_time_slots));
    read_chk("defer_pend", 8'h08, 32'h1 | cnt_field(1), 1'b1);
    push("auto_slots", 32'h10);
    push("auto_sweep", 32'h20);
    push("auto_upd", 32'h1);
    pulse_tick();
    pop_chk(32'(hw_pwm_time_slots));
    pop_chk(32'(hw_pwm_sweep_time));
    pop_chk(32'(hw_cfg_update));
    read_chk("auto_status", 8'h08, cnt_field(2), 1'b1);
    pulse_tick();
    obs_chk("tick_no_pend", 32'(hw_cfg_update), 32'd0);

    // back-to-back manual commits
    bus_write(8'h04, 32'h3, 1'b0);
    obs_chk("b2b_upd0", 32'(hw_cfg_update), 32'd1);
    bus_write(8'h04, 32'h3, 1'b0);
    obs_chk("b2b_upd1", 32'(hw_cfg_update), 32'd1);
    read_chk("b2b_status", 8'h08, cnt_field(4), 1'b1);

    // lock
    bus_write(8'h04, 32'h6, 1'b0);
    bus_write(8'h10, 32'h5, 1'b0);
    read_chk("lock_sh0", 8'h10, 32'h0000000A, 1'b1);
    read_chk("lock_err", 8'h08, 32'h2 | cnt_field(4), 1'b1);
    bus_write(8'h04, 32'h0, 1'b0);
    read_chk("lock_sticky", 8'h04, 32'h4, 1'b1);
    bus_write(8'h08, 32'h2, 1'b0);
    read_chk("w1c", 8'h08, cnt_field(4), 1'b1);

    // unmapped addresses and block select
    bus_write(8'h1C, 32'hFF, 1'b0);
    read_chk("unmap_err1", 8'h08, 32'h2 | cnt_field(4), 1'b1);
    read_chk("unmap_rd1c", 8'h1C, 32'h0, 1'b1);
    bus_write(8'h08, 32'h2, 1'b0);
    bus_write(8'h05, 32'hFF, 1'b0);
    read_chk("unmap_err2", 8'h08, 32'h2 | cnt_field(4), 1'b1);
    read_chk("unmap_rd05", 8'h05, 32'h0, 1'b1);
    read_chk("hole_0c", 8'h0C, 32'h0, 1'b1);
    read_chk("no_sel", 8'h14, 32'h0, 1'b0);
    bus_write(8'h08, 32'h2, 1'b0);

    // commit counter wrap (4 so far, 252 more reach 256)
    for (int i = 0; i < 252; i++) begin
      bus_write(8'h04, 32'h1, 1'b0);
      if (i == 123) read_chk("cnt_128", 8'h08, cnt_field(128), 1'b1);
    end
    read_chk("cnt_wrap", 8'h08, cnt_field(256), 1'b1);
    bus_write(8'h04, 32'h1, 1'b0);
    read_chk("cnt_after_wrap", 8'h08, cnt_field(257), 1'b1);

    // reset coinciding with a commit request
    push("mrst_upd", 32'h0);
    push("mrst_freq1", 32'd10);
    push("mrst_mag1", 32'h0);
    push("mrst_slots", 32'h0);
    @(negedge clk);
    bus.addr  = 6'h04;
    bus.wdata = 32'h1;
    bus.wr_en = 1'b1;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    pop_chk(32'(hw_cfg_update));
    pop_chk(fq(1));
    pop_chk(mg(1));
    pop_chk(32'(hw_pwm_time_slots));
    bus.wr_en = 1'b0;
    rst_n     = 1'b1;
    read_chk("mrst_status", 8'h08, 32'h0, 1'b1);
    read_chk("mrst_ctrl", 8'h04, 32'h0, 1'b1);
    read_chk("mrst_ch1", 8'h14, 32'h0000000A, 1'b1);
    read_chk("mrst_cfg", 8'h00, 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
